// File: rtl/rr_grant_master_ctrl_if.sv
// Requester/monitor bundle for the round-robin grant/master controller.
// The master modport is the requester side; the slave modport is the controller.
interface rr_grant_master_ctrl_if #(
  parameter int N_REQ = 3,
  parameter int MW    = 2
);
  logic [N_REQ-1:0] i_req;
  logic             i_ready;
  logic [N_REQ-1:0] o_grant;
  logic [MW-1:0]    o_master;
  logic             o_busy;
  logic             o_starve;

  modport master (
    output i_req, i_ready,
    input  o_grant, o_master, o_busy, o_starve
  );

  modport slave (
    input  i_req, i_ready,
    output o_grant, o_master, o_busy, o_starve
  );
endinterface

// File: rtl/rr_grant_master_ctrl.sv
// Round-robin arbiter producing a registered one-hot grant and a registered
// master index that follows the grant on every ready cycle.
// It also keeps per-requester wait counters and raises a sticky starvation flag.
module rr_grant_master_ctrl #(
  parameter int N_REQ      = 3,
  parameter int MW         = 2,
  parameter int STARVE_LIM = 4
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  rr_grant_master_ctrl_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [MW-1:0]    gidx_q, gidx_d;
  logic [MW-1:0]    master_q, master_d;
  logic [MW-1:0]    ptr_q, ptr_d;
  logic [MW-1:0]    commit_ptr;
  logic [MW:0]      sel_idle;
  logic [MW:0]      sel_commit;
  logic [CW-1:0]    wait_q [N_REQ];
  logic [CW-1:0]    wait_d [N_REQ];
  logic             starve_q, starve_d;

  // First requester at or after p (circularly); the MSB of the result flags a valid winner.
  function automatic logic [MW:0] pick(input logic [N_REQ-1:0] req, input logic [MW-1:0] p);
    logic [MW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (req[idx]) res = {1'b1, MW'(idx)};
    end
    return res;
  endfunction

  // Pointer after committing the current grant, and the winners under both pointers.
  always_comb begin
    commit_ptr = (int'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + 1'b1;
    sel_idle   = pick(bus.i_req, ptr_q);
    sel_commit = pick(bus.i_req, commit_ptr);
  end

  // Next-state logic: grant on any request from IDLE, commit and re-arbitrate on ready.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    master_d = master_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.i_ready) master_d = '1;
        if (sel_idle[MW]) begin
          state_d = GRANT;
          gidx_d  = sel_idle[MW-1:0];
          grant_d = N_REQ'(1) << sel_idle[MW-1:0];
        end
      end
      GRANT: begin
        if (bus.i_ready) begin
          master_d = gidx_q;
          ptr_d    = commit_ptr;
          if (sel_commit[MW]) begin
            gidx_d  = sel_commit[MW-1:0];
            grant_d = N_REQ'(1) << sel_commit[MW-1:0];
          end else begin
            state_d = IDLE;
            gidx_d  = '0;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Wait counters advance only on ready cycles; the starvation flag is sticky.
  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (bus.i_ready) begin
        if ((state_q == GRANT && int'(gidx_q) == i) || !bus.i_req[i]) begin
          wait_d[i] = '0;
        end else if (int'(wait_q[i]) < STARVE_LIM) begin
          wait_d[i] = wait_q[i] + 1'b1;
        end
      end
      if (int'(wait_d[i]) == STARVE_LIM) starve_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset taking priority over everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      master_q <= '1;
      ptr_q    <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign bus.o_grant  = grant_q;
  assign bus.o_master = master_q;
  assign bus.o_busy   = (state_q == GRANT);
  assign bus.o_starve = starve_q;

endmodule
